instruction_fetch: RTL and testbench

Initiator side of the instruction-memory read interface. Holds the program counter and drives the word address into the combinational instruction memory. Captures the returned word into a small fetch FIFO and presents it to decode with a valid/ready handshake. Accepts PC redirects from branch/jump resolution and detects halt and misaligned-target conditions.

---
 rtl/instruction_fetch.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC holder, instruction-memory initiator and fetch FIFO
module instruction_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2,
  parameter int          HALT_ON_ZERO = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_inst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_halted,
  output logic        o_fault
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } mode_t;

  mode_t          r_mode;
  mode_t          w_mode_next;
  logic           r_halted;
  logic           r_fault;
  logic           w_halted_next;
  logic           w_fault_next;

  logic [31:0]    r_pc;
  logic [31:0]    r_fifo_inst [FIFO_DEPTH];
  logic [31:0]    r_fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_last_inst;
  logic [31:0]    r_last_pc;

  logic           w_pop;
  logic           w_push;
  logic           w_zero_word;
  logic           w_redirect_aligned;
  logic           w_has_room;
  logic [31:0]    w_head_inst;
  logic [31:0]    w_head_pc;

  assign w_zero_word        = (HALT_ON_ZERO != 0) && (i_imem_inst == 32'h0);
  assign w_redirect_aligned = (i_redirect_pc[1:0] == 2'b00);
  assign w_pop              = o_inst_valid & i_inst_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_has_room         = (r_count < DEPTH_C) | w_pop;
  assign w_push             = (r_mode == S_RUN) & ~i_redirect_valid & w_has_room & ~w_zero_word;

  assign w_head_inst  = r_fifo_inst[r_rd_ptr];
  assign w_head_pc    = r_fifo_pc[r_rd_ptr];
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = (r_count != '0);
  // When empty, show the last presented entry so the outputs do not wander.
  assign o_inst       = o_inst_valid ? w_head_inst : r_last_inst;
  assign o_inst_pc    = o_inst_valid ? w_head_pc   : r_last_pc;
  assign o_halted     = r_halted;
  assign o_fault      = r_fault;

  // Mode state register with sticky halt/fault flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mode   <= S_RUN;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_mode   <= w_mode_next;
      r_halted <= w_halted_next;
      r_fault  <= w_fault_next;
    end
  end

  // Next mode: redirects dominate; a zero word only halts while running.
  always_comb begin
    w_mode_next   = r_mode;
    w_halted_next = r_halted;
    w_fault_next  = r_fault;
    if (i_redirect_valid) begin
      if (w_redirect_aligned) begin
        w_mode_next   = S_RUN;
        w_halted_next = 1'b0;
        w_fault_next  = 1'b0;
      end else begin
        w_mode_next  = S_FAULT;
        w_fault_next = 1'b1;
      end
    end else if ((r_mode == S_RUN) && w_zero_word) begin
      w_mode_next   = S_HALTED;
      w_halted_next = 1'b1;
    end
  end

  // Program counter: reset, aligned redirect, or advance on each push.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_redirect_valid) begin
      if (w_redirect_aligned) begin
        r_pc <= i_redirect_pc;
      end
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy; a redirect flushes and ignores any pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // FIFO storage write; contents are qualified by the occupancy count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= i_imem_inst;
      r_fifo_pc[r_wr_ptr]   <= r_pc;
    end
  end

  // Remember the most recently presented head for the empty case.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last_inst <= 32'h0;
      r_last_pc   <= 32'h0;
    end else if (o_inst_valid) begin
      r_last_inst <= w_head_inst;
      r_last_pc   <= w_head_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;

  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        halted;
  logic        fault;

  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_inst;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_halted;
  logic        w_fault;

  int checks;
  int failures;

  function automatic logic [31:0] prog(input logic [31:0] a);
    case (a)
      32'h0000_0000: prog = 32'h0010_8113;
      32'h0000_0004: prog = 32'h0010_8193;
      32'h0000_0008: prog = 32'h0031_0233;
      32'h0000_000C: prog = 32'hFE21_8AE3;
      32'hFFFF_FFFC: prog = 32'h0000_0013;
      default:       prog = 32'h0000_0000;
    endcase
  endfunction

  assign imem_inst   = prog(imem_addr);
  assign w_imem_inst = prog(w_imem_addr);

  instruction_fetch #(
    .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .HALT_ON_ZERO(1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr), .i_imem_inst(imem_inst),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_pc(inst_pc),
    .i_inst_ready(inst_ready), .o_halted(halted), .o_fault(fault)
  );

  instruction_fetch #(
    .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2), .HALT_ON_ZERO(1)
  ) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(w_imem_addr), .i_imem_inst(w_imem_inst),
    .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
    .o_inst_valid(w_inst_valid), .o_inst(w_inst), .o_inst_pc(w_inst_pc),
    .i_inst_ready(inst_ready), .o_halted(w_halted), .o_fault(w_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = ready;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++;
    if (inst_valid !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_ctrl valid=%b halted=%b fault=%b addr=%h required 0 0 0 00000000",
               inst_valid, halted, fault, imem_addr);
    end
    checks++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_data inst=%h pc=%h required 0 0", inst, inst_pc);
    end
  endtask

  task automatic test_stream_halt();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] || inst !== prog(exp_pc[i])) begin
        failures++;
        $display("FAIL stream_%0d valid=%b pc=%h inst=%h required 1 %h %h",
                 i, inst_valid, inst_pc, inst, exp_pc[i], prog(exp_pc[i]));
      end
      checks++;
      if (imem_addr[1:0] !== 2'b00) begin
        failures++;
        $display("FAIL stream_align_%0d addr=%h required low bits 00", i, imem_addr);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h10) begin
        failures++;
        $display("FAIL halt_%0d halted=%b valid=%b addr=%h required 1 0 00000010",
                 i, halted, inst_valid, imem_addr);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    checks++;
    if (imem_addr !== 32'h8 || inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0010_8113) begin
      failures++;
      $display("FAIL stall_hold addr=%h valid=%b pc=%h inst=%h required 00000008 1 00000000 00108113",
               imem_addr, inst_valid, inst_pc, inst);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] || inst !== prog(exp_pc[i])) begin
        failures++;
        $display("FAIL resume_%0d valid=%b pc=%h inst=%h required 1 %h %h",
                 i, inst_valid, inst_pc, inst, exp_pc[i], prog(exp_pc[i]));
      end
      tick();
    end
    checks++;
    if (inst_valid !== 1'b0 || halted !== 1'b1) begin
      failures++;
      $display("FAIL resume_drain valid=%b halted=%b required 0 1", inst_valid, halted);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h4;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h4 || halted !== 1'b0) begin
      failures++;
      $display("FAIL redirect_flush valid=%b addr=%h halted=%b required 0 00000004 0",
               inst_valid, imem_addr, halted);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== 32'h0010_8193) begin
      failures++;
      $display("FAIL redirect_first valid=%b pc=%h inst=%h required 1 00000004 00108193",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL fault_set fault=%b valid=%b addr=%h required 1 0 00000008",
               fault, inst_valid, imem_addr);
    end
    tick();
    tick();
    checks++;
    if (fault !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL fault_hold fault=%b valid=%b addr=%h required 1 0 00000008",
               fault, inst_valid, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL fault_clear fault=%b addr=%h required 0 00000000", fault, imem_addr);
    end
    tick();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0010_8113) begin
      failures++;
      $display("FAIL fault_refetch valid=%b pc=%h inst=%h required 1 00000000 00108113",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    checks++;
    if (w_imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_reset addr=%h required fffffffc", w_imem_addr);
    end
    tick();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC || w_inst !== 32'h0000_0013) begin
      failures++;
      $display("FAIL wrap_first valid=%b pc=%h inst=%h required 1 fffffffc 00000013",
               w_inst_valid, w_inst_pc, w_inst);
    end
    tick();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h0 || w_inst !== 32'h0010_8113) begin
      failures++;
      $display("FAIL wrap_second valid=%b pc=%h inst=%h required 1 00000000 00108113",
               w_inst_valid, w_inst_pc, w_inst);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    checks++;
    if (inst_valid !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL mid_full valid=%b addr=%h required 1 00000008", inst_valid, imem_addr);
    end
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h4;
    inst_ready = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || halted !== 1'b0 ||
        fault !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset valid=%b inst=%h pc=%h halted=%b fault=%b addr=%h required all zero",
               inst_valid, inst, inst_pc, halted, fault, imem_addr);
    end
    rst_n = 1'b1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    test_reset();
    test_stream_halt();
    test_backpressure();
    test_redirect();
    test_fault();
    test_wrap();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
